// File: rtl/assert_monitor_if.sv
// Check-request and event-record stream bundle for assert_monitor.
// The slave side is the monitor. The master side is the checked logic together with the log sink.
interface assert_monitor_if #(
  parameter int NUM_CH   = 4,
  parameter int WIDTH    = 8,
  parameter int TS_WIDTH = 32
);
  localparam int CHW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int REC_W = TS_WIDTH + 3 + CHW + 2*WIDTH;

  logic [NUM_CH-1:0]       chk_valid;
  logic [NUM_CH-1:0]       chk_ready;
  logic [NUM_CH-1:0]       chk_mode;
  logic [NUM_CH*WIDTH-1:0] chk_received;
  logic [NUM_CH*WIDTH-1:0] chk_expected;
  logic                    ev_valid;
  logic                    ev_ready;
  logic [REC_W-1:0]        ev_data;

  modport slave (
    input  chk_valid, chk_mode, chk_received, chk_expected, ev_ready,
    output chk_ready, ev_valid, ev_data
  );

  modport master (
    output chk_valid, chk_mode, chk_received, chk_expected, ev_ready,
    input  chk_ready, ev_valid, ev_data
  );
endinterface

// File: rtl/assert_monitor.sv
// Multi-channel EQ/NE checker with round-robin arbitration and pass/fail counters.
// Level-filtered event records go through a FWFT FIFO with a registered output.
module assert_monitor #(
  parameter int NUM_CH    = 4,
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int TS_WIDTH  = 32,
  parameter int CNT_WIDTH = 16,
  localparam int CHW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int AW    = $clog2(DEPTH),
  localparam int REC_W = TS_WIDTH + 3 + CHW + 2*WIDTH
)(
  input  logic                 clk,
  input  logic                 rst_n,
  assert_monitor_if.slave      bus,
  input  logic [2:0]           min_level,
  input  logic                 halt,
  output logic [CNT_WIDTH-1:0] pass_count,
  output logic [CNT_WIDTH-1:0] fail_count,
  output logic                 err_flag,
  output logic [AW:0]          fifo_level
);

  localparam logic [2:0] LVL_INFO  = 3'd2;
  localparam logic [2:0] LVL_ERROR = 3'd4;

  // A single sync stage makes the second rising edge after release the first active one.
  logic active_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) active_q <= 1'b0;
    else        active_q <= 1'b1;
  end

  logic [TS_WIDTH-1:0]  ts_q, ts_d;
  logic [CHW-1:0]       ptr_q, ptr_d;
  logic [CNT_WIDTH-1:0] pass_q, pass_d, fail_q, fail_d;
  logic                 err_q, err_d;
  logic [AW:0]          wr_q, wr_d, rd_q, rd_d;
  logic                 ev_valid_q, ev_valid_d;
  logic [REC_W-1:0]     ev_data_q, ev_data_d;
  logic [REC_W-1:0]     mem_q [DEPTH];

  // ptr_q is the first channel searched, i.e. the one after the last grant.
  logic           gnt_any;
  logic [CHW-1:0] gnt_idx;
  always_comb begin
    int c;
    gnt_any = 1'b0;
    gnt_idx = '0;
    c       = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      c = int'(ptr_q) + k;
      if (c >= NUM_CH) c = c - NUM_CH;
      if (!gnt_any && bus.chk_valid[CHW'(c)]) begin
        gnt_any = 1'b1;
        gnt_idx = CHW'(c);
      end
    end
  end

  logic [WIDTH-1:0] sel_rec, sel_exp;
  logic             pass, want_push, full, pop, accept, push;
  logic [2:0]       level;
  logic [AW:0]      cnt, cnt_d;
  logic [REC_W-1:0] rec;

  assign sel_rec   = bus.chk_received[gnt_idx*WIDTH +: WIDTH];
  assign sel_exp   = bus.chk_expected[gnt_idx*WIDTH +: WIDTH];
  assign pass      = (sel_rec == sel_exp) ^ bus.chk_mode[gnt_idx];
  assign level     = pass ? LVL_INFO : LVL_ERROR;
  assign want_push = (level >= min_level);
  assign cnt       = wr_q - rd_q;
  assign full      = (cnt == (AW+1)'(DEPTH));
  assign pop       = active_q & ev_valid_q & bus.ev_ready;
  // A full FIFO still takes a record when the head leaves in the same cycle.
  assign accept    = active_q & gnt_any & ~halt & (~full | pop | ~want_push);
  assign push      = accept & want_push;
  assign rec       = {ts_q, level, gnt_idx, sel_rec, sel_exp};

  always_comb begin
    bus.chk_ready = '0;
    if (accept) bus.chk_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    ts_d   = ts_q + 1'b1;
    ptr_d  = ptr_q;
    pass_d = pass_q;
    fail_d = fail_q;
    err_d  = err_q;
    if (accept) begin
      ptr_d = (gnt_idx == CHW'(NUM_CH-1)) ? '0 : gnt_idx + 1'b1;
      if (pass && pass_q != '1) pass_d = pass_q + 1'b1;
      if (!pass && fail_q != '1) fail_d = fail_q + 1'b1;
      if (!pass) err_d = 1'b1;
    end
    wr_d       = wr_q + {{AW{1'b0}}, push};
    rd_d       = rd_q + {{AW{1'b0}}, pop};
    cnt_d      = wr_d - rd_d;
    ev_valid_d = (cnt_d != '0);
    // The next head is the record written this cycle when it lands in the head slot.
    if (cnt_d == '0)
      ev_data_d = '0;
    else if (push && wr_q[AW-1:0] == rd_d[AW-1:0])
      ev_data_d = rec;
    else
      ev_data_d = mem_q[rd_d[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q       <= '0;
      ptr_q      <= '0;
      pass_q     <= '0;
      fail_q     <= '0;
      err_q      <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      ev_valid_q <= 1'b0;
      ev_data_q  <= '0;
    end else if (active_q) begin
      ts_q       <= ts_d;
      ptr_q      <= ptr_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      err_q      <= err_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      ev_valid_q <= ev_valid_d;
      ev_data_q  <= ev_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= rec;
  end

  assign bus.ev_valid = ev_valid_q;
  assign bus.ev_data  = ev_data_q;
  assign pass_count   = pass_q;
  assign fail_count   = fail_q;
  assign err_flag     = err_q;
  assign fifo_level   = cnt;

endmodule

// File: tb/tb_assert_monitor.sv
// Bench for assert_monitor: directed table, hand-written corner sequences, and random stimulus.
// A queue-based reference model tracks the expected record stream and counters.
module tb_assert_monitor;
  localparam int NUM_CH = 4, WIDTH = 8, DEPTH = 16, TSW = 32, CNTW = 16;
  localparam int REC_W = TSW + 3 + 2 + 2*WIDTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  assert_monitor_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .TS_WIDTH(TSW)) bus();
  logic [2:0]      min_level;
  logic            halt;
  logic [CNTW-1:0] pass_count, fail_count;
  logic            err_flag;
  logic [4:0]      fifo_level;

  assert_monitor #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .DEPTH(DEPTH), .TS_WIDTH(TSW), .CNT_WIDTH(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .min_level(min_level), .halt(halt),
    .pass_count(pass_count), .fail_count(fail_count), .err_flag(err_flag), .fifo_level(fifo_level));

  // Small instance for counter saturation and timestamp wrap.
  assert_monitor_if #(.NUM_CH(4), .WIDTH(8), .TS_WIDTH(4)) sbus();
  logic [3:0] s_pass, s_fail;
  logic       s_err;
  logic [2:0] s_level;
  logic       s_halt;
  assert_monitor #(.NUM_CH(4), .WIDTH(8), .DEPTH(4), .TS_WIDTH(4), .CNT_WIDTH(4)) sdut (
    .clk(clk), .rst_n(rst_n), .bus(sbus), .min_level(min_level), .halt(s_halt),
    .pass_count(s_pass), .fail_count(s_fail), .err_flag(s_err), .fifo_level(s_level));

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference model
  logic [REC_W-1:0] q[$];
  int               m_pass, m_fail, last_gnt, act_delay;
  bit               m_err;
  logic [31:0]      m_ts;
  logic [3:0]       last_ready;

  task automatic model_reset();
    q.delete();
    m_pass = 0; m_fail = 0; m_err = 0; m_ts = '0;
    last_gnt = NUM_CH - 1;
    act_delay = 1;
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic step(input logic [3:0] v, input logic [3:0] md, input logic [31:0] rc,
                      input logic [31:0] ex, input logic [2:0] ml, input logic h, input logic rdy);
    int g;
    bit active, popq, acc, ps, pu;
    logic [7:0] r, e;
    logic [2:0] lvl;
    logic [1:0] gc;
    longint unsigned exp_ready;
    chk("ev_valid", bus.ev_valid, q.size() != 0);
    if (q.size() != 0) chk("ev_data", bus.ev_data, q[0]);
    chk("fifo_level", fifo_level, q.size());
    chk("pass_count", pass_count, m_pass);
    chk("fail_count", fail_count, m_fail);
    chk("err_flag", err_flag, m_err);
    bus.chk_valid = v; bus.chk_mode = md; bus.chk_received = rc; bus.chk_expected = ex;
    min_level = ml; halt = h; bus.ev_ready = rdy;
    #1;
    active = rst_n && act_delay == 0;
    g = -1;
    if (active)
      for (int k = 1; k <= NUM_CH; k++)
        if (g < 0 && v[(last_gnt + k) % NUM_CH]) g = (last_gnt + k) % NUM_CH;
    popq = active && q.size() > 0 && rdy;
    acc = 0; ps = 0; pu = 0; r = '0; e = '0; lvl = '0;
    if (g >= 0 && !h) begin
      r = rc[g*8 +: 8];
      e = ex[g*8 +: 8];
      ps = (r == e) != md[g];
      lvl = ps ? 3'd2 : 3'd4;
      pu = lvl >= ml;
      acc = (q.size() < DEPTH) || popq || !pu;
    end
    exp_ready = acc ? (64'd1 << g) : 64'd0;
    last_ready = bus.chk_ready;
    chk("chk_ready", bus.chk_ready, exp_ready);
    if (popq) void'(q.pop_front());
    if (acc) begin
      last_gnt = g;
      gc = 2'(g);
      if (ps) begin if (m_pass < 65535) m_pass++; end
      else begin if (m_fail < 65535) m_fail++; m_err = 1; end
      if (pu) q.push_back({m_ts, lvl, gc, r, e});
    end
    if (active) m_ts = m_ts + 1;
    if (rst_n && act_delay > 0) act_delay--;
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    step(4'h0, 4'h0, 32'h0, 32'h0, 3'd0, 1'b0, rdy);
  endtask

  // Called at a negedge; leaves the DUT active and the model in sync.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_ev_valid", bus.ev_valid, 0);
    chk("rst_ev_data", bus.ev_data, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_counts", {pass_count, fail_count, 15'h0, err_flag}, 0);
    model_reset();
    @(negedge clk);
    idle(1'b1);
    rst_n = 1'b1;
    idle(1'b1);
  endtask

  typedef struct {
    int ch; bit mode; logic [7:0] r; logic [7:0] e; logic [2:0] ml;
    bit exp_push; logic [2:0] exp_lvl;
  } vec_t;
  vec_t tbl[10];

  logic [REC_W-1:0] want;
  logic [31:0] rc, ex, prev_ts;
  int accepts, wraps, prev_s, cur_s;
  bit have_prev;

  initial begin
    bus.chk_valid = '0; bus.chk_mode = '0; bus.chk_received = '0; bus.chk_expected = '0;
    bus.ev_ready = 1'b0; min_level = '0; halt = 1'b0;
    sbus.chk_valid = '0; sbus.chk_mode = '0; sbus.chk_received = '0; sbus.chk_expected = '0;
    sbus.ev_ready = 1'b0; s_halt = 1'b0;
    tbl[0] = '{0, 0, 8'h11, 8'h11, 3'd0, 1, 3'd2};
    tbl[1] = '{1, 0, 8'h11, 8'h12, 3'd0, 1, 3'd4};
    tbl[2] = '{2, 1, 8'hFF, 8'h00, 3'd3, 0, 3'd0};
    tbl[3] = '{3, 1, 8'h07, 8'h07, 3'd4, 1, 3'd4};
    tbl[4] = '{0, 0, 8'h00, 8'h00, 3'd2, 1, 3'd2};
    tbl[5] = '{1, 0, 8'h01, 8'h00, 3'd5, 0, 3'd0};
    tbl[6] = '{2, 0, 8'hAA, 8'hAA, 3'd6, 0, 3'd0};
    tbl[7] = '{3, 1, 8'hAA, 8'hAA, 3'd7, 0, 3'd0};
    tbl[8] = '{0, 1, 8'h80, 8'h00, 3'd4, 0, 3'd0};
    tbl[9] = '{1, 0, 8'h80, 8'h81, 3'd4, 1, 3'd4};

    @(negedge clk);
    do_reset();

    // Single EQ pass accepted at ts = 10
    for (int i = 0; i < 40 && m_ts != 10; i++) idle(1'b1);
    chk("t1_ts_reached", m_ts, 10);
    step(4'b0001, 4'h0, 32'h5A, 32'h5A, 3'd2, 1'b0, 1'b1);
    want = {32'd10, 3'd2, 2'd0, 8'h5A, 8'h5A};
    chk("t1_record", bus.ev_data, want);
    chk("t1_pass", pass_count, 1);
    chk("t1_err", err_flag, 0);

    // NE fail on ch2, then a filtered pass
    do_reset();
    step(4'b0100, 4'b0100, 32'h0033_0000, 32'h0033_0000, 3'd4, 1'b0, 1'b1);
    chk("t2_valid", bus.ev_valid, 1);
    chk("t2_level", bus.ev_data[20:18], 4);
    chk("t2_ch", bus.ev_data[17:16], 2);
    chk("t2_fail", fail_count, 1);
    chk("t2_err", err_flag, 1);
    step(4'b0100, 4'b0000, 32'h0033_0000, 32'h0033_0000, 3'd4, 1'b0, 1'b1);
    chk("t2_filtered", bus.ev_valid, 0);
    chk("t2_pass", pass_count, 1);

    // Table of single-channel checks
    for (int i = 0; i < 10; i++) begin
      rc = 32'(tbl[i].r) << (tbl[i].ch * 8);
      ex = 32'(tbl[i].e) << (tbl[i].ch * 8);
      step(4'(1 << tbl[i].ch), 4'(tbl[i].mode) << tbl[i].ch, rc, ex, tbl[i].ml, 1'b0, 1'b1);
      chk($sformatf("tbl%0d_push", i), bus.ev_valid, tbl[i].exp_push);
      if (tbl[i].exp_push) chk($sformatf("tbl%0d_lvl", i), bus.ev_data[20:18], tbl[i].exp_lvl);
    end

    // Round-robin with all channels requesting
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(4'hF, 4'h0, 32'h0102_0304, 32'h0102_0304, 3'd0, 1'b0, 1'b1);
      chk("rr_ch", bus.ev_data[17:16], i % 4);
      if (i > 0) chk("rr_ts", bus.ev_data[52:21], prev_ts + 1);
      prev_ts = bus.ev_data[52:21];
    end

    // Fill to full with back-pressure
    do_reset();
    for (int i = 0; i < 18; i++) step(4'b0001, 4'h0, 32'h1, 32'h0, 3'd0, 1'b0, 1'b0);
    chk("full_level", fifo_level, 16);
    chk("full_ready", last_ready, 0);
    for (int i = 0; i < 3; i++) step(4'b0001, 4'h0, 32'h5, 32'h5, 3'd4, 1'b0, 1'b0);
    chk("full_filtered_pass", pass_count, 3);
    step(4'b0001, 4'h0, 32'h1, 32'h0, 3'd0, 1'b0, 1'b1);
    chk("full_pushpop_ready", last_ready, 1);
    chk("full_pushpop_level", fifo_level, 16);
    chk("full_pushpop_fail", fail_count, 17);

    // halt with requests pending: drains, counters freeze
    for (int i = 0; i < 40 && fifo_level != 0; i++) step(4'hF, 4'h0, 32'h0, 32'h0, 3'd0, 1'b1, 1'b1);
    chk("halt_drained", fifo_level, 0);
    chk("halt_fail_frozen", fail_count, 17);
    chk("halt_ready", last_ready, 0);

    // Reset mid-operation with 5 records queued
    do_reset();
    for (int i = 0; i < 5; i++) step(4'b0010, 4'h0, 32'h100, 32'h0, 3'd0, 1'b0, 1'b0);
    chk("mid_level", fifo_level, 5);
    do_reset();

    // Random traffic against the model
    for (int i = 0; i < 500; i++) begin
      for (int c = 0; c < 4; c++) begin
        rc[c*8 +: 8] = 8'($urandom);
        ex[c*8 +: 8] = ($urandom_range(0, 1) == 1) ? rc[c*8 +: 8] : 8'($urandom);
      end
      step(4'($urandom), 4'($urandom), rc, ex, 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 2) != 0));
    end

    // Small instance: saturation and timestamp wrap
    idle(1'b1);
    do_reset();
    min_level = 3'd0;
    sbus.ev_ready = 1'b1;
    sbus.chk_valid = 4'b0001;
    accepts = 0; wraps = 0; have_prev = 0; prev_s = 0;
    for (int i = 0; i < 60 && accepts < 20; i++) begin
      #1;
      if (sbus.chk_ready[0]) accepts++;
      @(negedge clk);
      if (sbus.ev_valid) begin
        cur_s = int'(sbus.ev_data[24:21]);
        if (have_prev) begin
          chk("s_ts_consec", cur_s, (prev_s + 1) % 16);
          if (prev_s == 15 && cur_s == 0) wraps++;
        end
        have_prev = 1;
        prev_s = cur_s;
      end
    end
    sbus.chk_valid = '0;
    chk("s_accepts", accepts, 20);
    chk("s_wrap_seen", wraps > 0, 1);
    @(negedge clk);
    chk("s_pass_sat", s_pass, 15);
    chk("s_fail", s_fail, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/assert_monitor.md
Name: assert_monitor

Overview:
- Synthesizable multi-channel assertion checker and event recorder; hardware counterpart of the simulation assert/capture utilities.
- Each channel presents received/expected word pairs with a per-check mode (EQ or NE).
- The block arbitrates among channels, judges pass/fail and keeps pass/fail counters.
- Level-filtered event records (timestamp, level, channel, operands) are pushed into a FIFO and drained over a valid/ready stream to a log sink or DMA.

Parameters:
- NUM_CH, 4: number of check channels (1..16).
- WIDTH, 8: bit width of received/expected words.
- DEPTH, 16: event FIFO depth in records; power of two, >= 2.
- TS_WIDTH, 32: timestamp counter width.
- CNT_WIDTH, 16: pass/fail counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- chk_valid  in  NUM_CH  per-channel check request.
- chk_ready  out  NUM_CH  per-channel accept; one-hot or zero.
- chk_mode  in  NUM_CH  per-channel mode: 0 = EQ (pass if equal), 1 = NE (pass if not equal).
- chk_received  in  NUM_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- chk_expected  in  NUM_CH*WIDTH  same packing as chk_received.
- min_level  in  3  record filter; levels are TRACE=0, DEBUG=1, INFO=2, WARN=3, ERROR=4, FATAL=5.
- halt  in  1  stop accepting new checks; FIFO continues to drain.
- ev_valid  out  1  event record available.
- ev_ready  in  1  sink accepts record.
- ev_data  out  REC_W  record {ts[TS_WIDTH], level[3], ch[CHW], received[WIDTH], expected[WIDTH]}, MSB first.
  - CHW = max(1, clog2(NUM_CH)); REC_W = TS_WIDTH + 3 + CHW + 2*WIDTH.
- pass_count  out  CNT_WIDTH  saturating count of passing checks.
- fail_count  out  CNT_WIDTH  saturating count of failing checks.
- err_flag  out  1  sticky; set on the first failing check.
- fifo_level  out  clog2(DEPTH)+1  records currently held.

Behaviour:
- Reset (rst_n low, asynchronous):
  - outputs: chk_ready = 0, ev_valid = 0, ev_data = 0, pass_count = 0, fail_count = 0, err_flag = 0, fifo_level = 0.
  - internal: timestamp = 0, round-robin pointer = 0, FIFO pointers = 0.
  - Deassertion is synchronised internally; first active edge is the second rising clk after rst_n rises.
  - Reset mid-drain discards all FIFO contents.
- Timestamp: free-running, increments every cycle, wraps 2^TS_WIDTH-1 -> 0 with no flag.
- Arbitration:
  - Round-robin over channels with chk_valid = 1.
  - Search starts at the channel after the last granted one.
  - At most one grant per cycle.
  - chk_ready is combinational from chk_valid, pointer, halt and FIFO state.
- Accept condition: grant AND NOT halt AND (FIFO not full OR record filtered out).
  - Filtered checks are accepted even when the FIFO is full.
  - Ungranted channels hold their request; each channel is served within NUM_CH cycles when not blocked.
- Judgement on accept:
  - pass = (received == expected) XOR mode.
  - level = INFO (2) on pass, ERROR (4) on fail.
  - Record is pushed only if level >= min_level.
  - min_level 6 or 7 filters everything.
- Counters:
  - pass_count/fail_count update on every accepted check regardless of filtering; they saturate at all-ones.
  - err_flag sets on any accepted fail and clears only on reset.
  - Counter outputs are registered: they reflect a check in the cycle after acceptance.
- Record timestamp is the counter value in the acceptance cycle.
- FIFO:
  - Registered output, first-word-fall-through.
  - A record accepted in cycle t is on ev_data with ev_valid = 1 from cycle t+1.
  - Pop when ev_valid AND ev_ready.
  - Simultaneous push and pop when full: push is allowed (pop frees the slot); fifo_level unchanged.
  - Simultaneous push and pop when empty: the pushed record appears at t+1; no bypass in the same cycle.
  - ev_data is held stable while ev_valid = 1 AND ev_ready = 0.
  - Pointer wrap-around is modulo DEPTH, with an extra bit for full/empty detection.
- halt:
  - chk_ready = 0 from the same cycle halt is asserted.
  - Counters freeze; the timestamp keeps running.

Test Plan:
- Single EQ pass: ch0 rec = 0x5A, exp = 0x5A, min_level = 2, at ts = 10 -> one record {10, 2, 0, 5A, 5A} at t+1; pass_count = 1; err_flag = 0.
- NE fail plus filter:
  - ch2 mode = 1, rec = exp = 0x33, min_level = 4 -> record level 4, ch = 2; fail_count = 1; err_flag = 1.
  - Then a passing check -> no record; pass_count = 1.
- Round-robin: all 4 channels valid continuously for 8 cycles, ev_ready = 1 -> grants 0,1,2,3,0,1,2,3; records in that order with consecutive timestamps.
- Full/backpressure:
  - ev_ready = 0, ch0 streams fails -> fifo_level reaches 16 and chk_ready drops.
  - Passes with min_level = 4 are still accepted.
  - ev_ready = 1 for one cycle with ch0 valid -> push and pop in the same cycle; level stays 16.
- Saturation/wrap: CNT_WIDTH = 4 with 20 passes -> pass_count = 15. TS_WIDTH = 4 -> timestamp wraps 15 -> 0 in records.
- halt and reset mid-operation:
  - halt = 1 with valids pending -> chk_ready = 0; FIFO drains to 0.
  - rst_n low with 5 records queued -> ev_valid = 0 immediately; counters = 0.
